// File: rtl/cb_pkg.sv
// Shared sizing, frame-layout and track-order helpers for the multi-context connection block.
package cb_pkg;

  typedef enum logic [2:0] {
    TG_SINGLE0,
    TG_SINGLE1,
    TG_DOUBLE0,
    TG_DOUBLE1,
    TG_GLOBAL
  } trk_group_e;

  function automatic int cb_tracks(input int ws, input int wd, input int wg);
    return 2 * ws + 2 * wd + wg;
  endfunction

  function automatic int cb_selw(input int t);
    return $clog2(t + 1);
  endfunction

  function automatic int cb_ctxw(input int nctx);
    return (nctx > 1) ? $clog2(nctx) : 1;
  endfunction

  function automatic int cb_clb_bits(input int clbin, input int clbout, input int carry,
                                     input int t);
    return clbin * cb_selw(t) + clbout * t + carry;
  endfunction

  function automatic int cb_frame_len(input int nclb, input int clbin, input int clbout,
                                      input int carry, input int t);
    return nclb * cb_clb_bits(clbin, clbout, carry, t);
  endfunction

  // Per-CLB slice layout: input selectors, then output masks, then carry enables.
  function automatic int cb_in_off(input int c, input int p, input int per, input int selw);
    return c * per + p * selw;
  endfunction

  function automatic int cb_out_off(input int c, input int o, input int per, input int clbin,
                                    input int selw, input int t);
    return c * per + clbin * selw + o * t;
  endfunction

  function automatic int cb_carry_off(input int c, input int k, input int per, input int clbin,
                                      input int selw, input int clbout, input int t);
    return c * per + clbin * selw + clbout * t + k;
  endfunction

  function automatic int cb_track_base(input trk_group_e g, input int ws, input int wd);
    int base;
    case (g)
      TG_SINGLE0: base = 0;
      TG_SINGLE1: base = ws;
      TG_DOUBLE0: base = 2 * ws;
      TG_DOUBLE1: base = 2 * ws + wd;
      default:    base = 2 * ws + 2 * wd;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/cb_cfg_plane.sv
// Configuration store: serial shadow register, bit counter, context planes,
// commit/error tracking and active-context selection.
module cb_cfg_plane
  import cb_pkg::*;
#(
  parameter  int L    = 342,
  parameter  int NCTX = 2,
  localparam int CW   = cb_ctxw(NCTX),
  localparam int CNTW = $clog2(L + 2)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          cen_i,
  input  logic          shift_in_i,
  input  logic          set_in_i,
  input  logic [CW-1:0] ctx_wr_i,
  input  logic [CW-1:0] ctx_sel_i,
  output logic          shift_out_o,
  output logic          cfg_ready_o,
  output logic          cfg_err_o,
  output logic [CW-1:0] ctx_act_o,
  output logic [L-1:0]  act_cfg_o
);

  logic [L-1:0]    shadow_q, shadow_d;
  logic [L-1:0]    plane_q [NCTX];
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [CW-1:0]   ctx_q, ctx_d;
  logic            wr_valid, sel_valid, commit_ok;

  assign wr_valid  = int'(ctx_wr_i) < NCTX;
  assign sel_valid = int'(ctx_sel_i) < NCTX;
  assign commit_ok = set_in_i && (cnt_q == CNTW'(L)) && wr_valid;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path leaves it unassigned (no latch).
    shadow_d = cen_i ? {shadow_q[L-2:0], shift_in_i} : shadow_q;
    cnt_d    = cnt_q;
    if (set_in_i) begin
      cnt_d = cen_i ? CNTW'(1) : '0;
    end else if (cen_i && (cnt_q != CNTW'(L + 1))) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    err_d = err_q | (set_in_i & ~commit_ok) | ~sel_valid;
    ctx_d = sel_valid ? ctx_sel_i : ctx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ctx_q    <= '0;
      // NOTE: the context planes are reset too, so a reset leaves every track undriven.
      for (int i = 0; i < NCTX; i++) plane_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ctx_q    <= ctx_d;
      for (int i = 0; i < NCTX; i++) begin
        if (commit_ok && (int'(ctx_wr_i) == i)) plane_q[i] <= shadow_q;
      end
    end
  end

  assign shift_out_o = shadow_q[L-1];
  assign cfg_ready_o = (cnt_q == CNTW'(L));
  assign cfg_err_o   = err_q;
  assign ctx_act_o   = ctx_q;
  assign act_cfg_o   = plane_q[ctx_q];

endmodule

// File: rtl/connection_block_mc.sv
// Multi-context connection block: routes tracks to CLB inputs, CLB outputs onto tracks
// and carry between neighbouring CLBs, all under the active configuration plane.
module connection_block_mc
  import cb_pkg::*;
#(
  parameter  int WS     = 4,
  parameter  int WD     = 8,
  parameter  int WG     = 0,
  parameter  int NCLB   = 2,
  parameter  int CLBIN  = 10,
  parameter  int CLBOUT = 5,
  parameter  int CARRY  = 1,
  parameter  int NCTX   = 2,
  localparam int T      = cb_tracks(WS, WD, WG),
  localparam int SELW   = cb_selw(T),
  localparam int PER    = cb_clb_bits(CLBIN, CLBOUT, CARRY, T),
  localparam int L      = cb_frame_len(NCLB, CLBIN, CLBOUT, CARRY, T),
  localparam int CW     = cb_ctxw(NCTX),
  localparam int GW     = (WG > 0) ? WG : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    shift_in,
  output logic                    shift_out,
  input  logic                    set_in,
  input  logic [CW-1:0]           ctx_wr,
  input  logic [CW-1:0]           ctx_sel,
  output logic [CW-1:0]           ctx_act,
  output logic                    cfg_ready,
  output logic                    cfg_err,
  output logic                    drv_conflict,
  inout  wire  [WS-1:0]           single0,
  inout  wire  [WS-1:0]           single1,
  inout  wire  [WD-1:0]           double0,
  inout  wire  [WD-1:0]           double1,
  inout  wire  [GW-1:0]           global_trk,
  input  logic [NCLB*CLBOUT-1:0]  clb_output,
  input  logic [NCLB*CARRY-1:0]   clb_cout,
  output logic [NCLB*CLBIN-1:0]   clb_input,
  output logic [NCLB*CARRY-1:0]   clb_cin
);

  logic [L-1:0] act_cfg;
  logic [T-1:0] trk_rd, drv_en, drv_val, any_drv, multi_d, conflict_q;

  cb_cfg_plane #(.L(L), .NCTX(NCTX)) u_cfg (
    .clk        (clk),
    .rst_ni     (rst),
    .cen_i      (cen),
    .shift_in_i (shift_in),
    .set_in_i   (set_in),
    .ctx_wr_i   (ctx_wr),
    .ctx_sel_i  (ctx_sel),
    .shift_out_o(shift_out),
    .cfg_ready_o(cfg_ready),
    .cfg_err_o  (cfg_err),
    .ctx_act_o  (ctx_act),
    .act_cfg_o  (act_cfg)
  );

  for (genvar i = 0; i < WS; i++) begin : g_single
    localparam int K0 = cb_track_base(TG_SINGLE0, WS, WD) + i;
    localparam int K1 = cb_track_base(TG_SINGLE1, WS, WD) + i;
    assign trk_rd[K0] = single0[i];
    assign trk_rd[K1] = single1[i];
    assign single0[i] = drv_en[K0] ? drv_val[K0] : 1'bz;
    assign single1[i] = drv_en[K1] ? drv_val[K1] : 1'bz;
  end

  for (genvar i = 0; i < WD; i++) begin : g_double
    localparam int K0 = cb_track_base(TG_DOUBLE0, WS, WD) + i;
    localparam int K1 = cb_track_base(TG_DOUBLE1, WS, WD) + i;
    assign trk_rd[K0] = double0[i];
    assign trk_rd[K1] = double1[i];
    assign double0[i] = drv_en[K0] ? drv_val[K0] : 1'bz;
    assign double1[i] = drv_en[K1] ? drv_val[K1] : 1'bz;
  end

  if (WG > 0) begin : g_global
    for (genvar i = 0; i < WG; i++) begin : g_bit
      localparam int K = cb_track_base(TG_GLOBAL, WS, WD) + i;
      assign trk_rd[K]     = global_trk[i];
      assign global_trk[i] = drv_en[K] ? drv_val[K] : 1'bz;
    end
  end else begin : g_no_global
    assign global_trk = 1'bz;
  end

  // Selector k in 1..T picks track k-1; 0 and out-of-range codes leave the pin at 0.
  always_comb begin
    clb_input = '0;
    for (int c = 0; c < NCLB; c++) begin
      for (int p = 0; p < CLBIN; p++) begin
        for (int t = 0; t < T; t++) begin
          if (int'(act_cfg[cb_in_off(c, p, PER, SELW) +: SELW]) == t + 1)
            clb_input[c*CLBIN+p] = trk_rd[t];
        end
      end
    end
  end

  always_comb begin
    any_drv = '0;
    multi_d = '0;
    drv_val = '0;
    // NOTE: blocking assignments here build per-track accumulators within one evaluation.
    for (int t = 0; t < T; t++) begin
      for (int c = 0; c < NCLB; c++) begin
        for (int o = 0; o < CLBOUT; o++) begin
          if (act_cfg[cb_out_off(c, o, PER, CLBIN, SELW, T) + t]) begin
            multi_d[t] = multi_d[t] | any_drv[t];
            any_drv[t] = 1'b1;
            drv_val[t] = drv_val[t] | clb_output[c*CLBOUT+o];
          end
        end
      end
    end
    drv_en = any_drv & ~conflict_q;
  end

  always_comb begin
    clb_cin = '0;
    for (int c = 1; c < NCLB; c++) begin
      for (int k = 0; k < CARRY; k++) begin
        if (act_cfg[cb_carry_off(c, k, PER, CLBIN, SELW, CLBOUT, T)])
          clb_cin[c*CARRY+k] = clb_cout[(c-1)*CARRY+k];
      end
    end
  end

  // Contended tracks are released one cycle after the active plane enables them twice.
  always_ff @(posedge clk) begin
    if (!rst) conflict_q <= '0;
    else      conflict_q <= multi_d;
  end

  assign drv_conflict = |conflict_q;

endmodule
